fc1_weight_streamer: RTL



---
 rtl/fc1_weight_streamer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fc1_weight_streamer.sv
// FC1 weight streamer: prefetches packed int8 weight groups from a 1-cycle-latency
// SRAM into a small FIFO and presents them one at a time on a valid/next handshake.
module fc1_weight_streamer #(
    parameter int NUM_PE     = 4,
    parameter int IN1_N      = 132,
    parameter int OUT1_M     = 10,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ADDR_W-1:0]   i_base_addr,
    output logic                o_mem_en,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [8*NUM_PE-1:0] i_mem_rdata,
    output logic [8*NUM_PE-1:0] o_w_group,
    output logic                o_w_valid,
    input  logic                i_w_next,
    output logic [8:0]          o_group_idx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_next
);
    localparam int WORD_W = 8*NUM_PE;
    localparam int CNT_W  = 9;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  NUM_GROUPS = CNT_W'(IN1_N*OUT1_M/NUM_PE);
    localparam logic [CNT_W-1:0]  LAST_GROUP = NUM_GROUPS - CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W:0]   DEPTH_EXT  = (FCNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_issued_cnt;
    logic [CNT_W-1:0]    r_pop_cnt;
    logic                r_inflight;
    logic [WORD_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FCNT_W-1:0]   r_fifo_cnt;
    logic                r_done;
    logic                r_err_next;

    logic                w_active;
    logic                w_start_acc;
    logic                w_abort;
    logic                w_flush;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_last_pop;
    logic                w_bad_next;
    logic                w_issue;
    logic [FCNT_W-1:0]   w_cnt_after_pop;
    logic [FCNT_W:0]     w_occupancy;
    logic [ADDR_W-1:0]   w_rd_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Handshake strobes, read-issue decision and next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_active        = (r_state != S_IDLE);
        w_start_acc     = 1'b0;
        w_abort         = 1'b0;
        w_valid         = (r_fifo_cnt != {FCNT_W{1'b0}});
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_last_pop      = 1'b0;
        w_bad_next      = 1'b0;
        w_issue         = 1'b0;
        w_cnt_after_pop = r_fifo_cnt;
        w_occupancy     = {(FCNT_W+1){1'b0}};
        w_rd_addr       = r_base + ADDR_W'(r_issued_cnt);

        if (w_active) begin
            w_abort = i_abort;
        end else begin
            w_start_acc = i_start && !i_abort;
        end

        if (w_active && !i_abort) begin
            w_pop      = w_valid && i_w_next;
            w_push     = r_inflight;
            w_bad_next = i_w_next && !w_valid;
            w_last_pop = w_pop && (r_pop_cnt == LAST_GROUP);
        end else begin
            w_pop      = 1'b0;
        end

        // Room is judged after this cycle's pop; the in-flight word already owns a slot.
        w_cnt_after_pop = r_fifo_cnt - FCNT_W'(w_pop);
        w_occupancy     = {1'b0, w_cnt_after_pop} + (FCNT_W+1)'(r_inflight);
        if ((r_state == S_RUN) && !i_abort && (r_issued_cnt < NUM_GROUPS)) begin
            w_issue = (w_occupancy < DEPTH_EXT);
        end else begin
            w_issue = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_abort || w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_issued_cnt == NUM_GROUPS) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (i_abort || w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_flush = w_abort || w_start_acc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run bookkeeping: base address, issue and pop counters, in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base       <= {ADDR_W{1'b0}};
            r_issued_cnt <= {CNT_W{1'b0}};
            r_pop_cnt    <= {CNT_W{1'b0}};
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_acc) begin
                r_base       <= i_base_addr;
                r_issued_cnt <= {CNT_W{1'b0}};
                r_pop_cnt    <= {CNT_W{1'b0}};
            end else if (w_abort) begin
                r_pop_cnt    <= {CNT_W{1'b0}};
            end else begin
                if (w_issue) begin
                    r_issued_cnt <= r_issued_cnt + CNT_W'(1'b1);
                end
                if (w_last_pop) begin
                    r_pop_cnt <= {CNT_W{1'b0}};
                end else if (w_pop) begin
                    r_pop_cnt <= r_pop_cnt + CNT_W'(1'b1);
                end
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; a flush discards any late SRAM return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_fifo_cnt <= {FCNT_W{1'b0}};
        end else if (w_flush) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_fifo_cnt <= {FCNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_fifo_cnt <= r_fifo_cnt + FCNT_W'(w_push) - FCNT_W'(w_pop);
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= {WORD_W{1'b0}};
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= i_mem_rdata;
        end
    end

    // Completion pulse and sticky protocol-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_err_next <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            if (w_start_acc) begin
                r_err_next <= 1'b0;
            end else if (w_bad_next) begin
                r_err_next <= 1'b1;
            end
        end
    end

    assign o_mem_en    = w_issue;
    assign o_mem_addr  = w_issue ? w_rd_addr : {ADDR_W{1'b0}};
    assign o_w_group   = r_fifo[r_rd_ptr];
    assign o_w_valid   = w_valid;
    assign o_group_idx = r_pop_cnt;
    assign o_busy      = w_active;
    assign o_done      = r_done;
    assign o_err_next  = r_err_next;

endmodule
